bomb_ctrl: RTL and testbench

- Writer side of the 256-entry x 4-bit tile map that the map renderer reads.
- Accepts a bomb-placement request at a tile address and writes bomb code 4.
- Counts a fuse in frame ticks, then propagates an explosion (code 5) in four directions, stopping at obstacles, and destroys breakable obstacles.
- After the blast time it restores every exploded tile to path (code 1).
- Drives the map RAM's write port and a second, synchronous read port; handles one bomb at a time.

---
 rtl/map_pkg.sv | 78 +++++++
 rtl/blast_list.sv | 81 ++++++++
 rtl/bomb_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_bomb_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// ---------------------------------------------------------------------------
// map_pkg
// Shared definitions for the 16x16 tile map. The map renderer and the bomb
// controller both import this package so that tile codes and geometry agree.
//
// Contents:
//   MAP_W / MAP_H     map size in tiles
//   ADDR_W / TILE_W   tile address width ({y[3:0], x[3:0]}) and code width
//   TILE_*            tile codes stored in the map RAM
//   dir_t             blast propagation direction, in scan order
//   nbr_t/neighbour() tile at a given distance from a centre, with an
//                     in-bounds flag (the map does not wrap at its edges)
// ---------------------------------------------------------------------------
package map_pkg;

  localparam int MAP_W  = 16;
  localparam int MAP_H  = 16;
  localparam int ADDR_W = 8;
  localparam int TILE_W = 4;

  typedef logic [TILE_W-1:0] tile_t;
  typedef logic [ADDR_W-1:0] tile_addr_t;

  localparam tile_t TILE_SURR = 4'd0;  // surrounding / border
  localparam tile_t TILE_PATH = 4'd1;  // walkable path
  localparam tile_t TILE_OBS1 = 4'd2;  // indestructible obstacle
  localparam tile_t TILE_OBS2 = 4'd3;  // destructible obstacle
  localparam tile_t TILE_BOMB = 4'd4;  // armed bomb
  localparam tile_t TILE_EXPL = 4'd5;  // explosion

  // Scan order of the blast: up, down, left, right.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic       valid;  // neighbour lies inside the map
    tile_addr_t addr;
  } nbr_t;

  // Tile 'step' tiles away from 'centre' in direction 'dir'. Coordinates are
  // widened to 5 bits so that crossing an edge is detected instead of wrapping.
  function automatic nbr_t neighbour(input tile_addr_t centre, input dir_t dir,
                                     input logic [3:0] step);
    logic [4:0] x;
    logic [4:0] y;
    logic [4:0] s;
    nbr_t       n;
    x = {1'b0, centre[3:0]};
    y = {1'b0, centre[7:4]};
    s = {1'b0, step};
    n.valid = 1'b1;
    case (dir)
      DIR_UP: begin
        n.valid = (s <= y);
        y       = y - s;
      end
      DIR_DOWN: begin
        y       = y + s;
        n.valid = (y <= 5'(MAP_H - 1));
      end
      DIR_LEFT: begin
        n.valid = (s <= x);
        x       = x - s;
      end
      default: begin
        x       = x + s;
        n.valid = (x <= 5'(MAP_W - 1));
      end
    endcase
    n.addr = {y[3:0], x[3:0]};
    return n;
  endfunction

endpackage

// File: rtl/blast_list.sv
// ---------------------------------------------------------------------------
// blast_list
// Small register FIFO remembering which tiles were turned into explosion
// tiles, so they can be restored later in the same order.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clr           synchronous clear (empties the list)
//   i_push, i_data  append one entry (ignored when full)
//   i_pop           drop the head entry (ignored when empty)
//   o_head          current head entry (valid when !o_empty)
//   o_empty         list holds no entries
// ---------------------------------------------------------------------------
module blast_list #(
  parameter int DEPTH  = 9,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; an entry is only ever read after it has been
  // written, so clearing it would cost a reset net per bit for no benefit.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge, independent of order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bomb_ctrl.sv
// ---------------------------------------------------------------------------
// bomb_ctrl
// Writer side of the 256 x 4-bit tile map. Places one bomb at a time, waits
// out the fuse, spreads the explosion in four directions (stopping at
// obstacles, destroying breakable ones), then restores the exploded tiles
// to path after the blast time.
//
// Ports:
//   i_pclk, i_rst_n  pixel clock, asynchronous active-low reset
//   i_tick           one-cycle frame strobe used for fuse/blast timing
//   i_place          placement request pulse, with i_place_addr {y,x}
//   o_busy           high from request acceptance until clearing is done
//   o_raddr          registered map read address
//   i_rdata          map read data, valid the cycle after o_raddr
//   o_we/o_waddr/o_wdata  map write port, one write per strobe
//   o_blast          one-cycle pulse when the explosion starts
// ---------------------------------------------------------------------------
module bomb_ctrl
  import map_pkg::*;
#(
  parameter int FUSE_TICKS  = 120,
  parameter int BLAST_TICKS = 30,
  parameter int RANGE       = 2
) (
  input  logic              i_pclk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_place,
  input  logic [ADDR_W-1:0] i_place_addr,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [TILE_W-1:0] i_rdata,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [TILE_W-1:0] o_wdata,
  output logic              o_blast
);

  // Centre plus RANGE tiles in each of four directions: the list can never
  // overflow.
  localparam int LIST_DEPTH = 1 + 4 * RANGE;
  localparam int TICK_MAX   = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int CNT_W      = $clog2(TICK_MAX + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK_WAIT,     // read address out, RAM busy
    ST_CHK_EVAL,     // read data of the requested tile is valid
    ST_FUSE,
    ST_BLAST_START,
    ST_SCAN_ISSUE,   // pick next neighbour or end the direction
    ST_SCAN_WAIT,
    ST_SCAN_EVAL,
    ST_HOLD,
    ST_CLEAR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  tile_addr_t        r_centre;
  tile_addr_t        w_centre_nxt;
  dir_t              r_dir;
  dir_t              w_dir_nxt;
  logic [3:0]        r_step;
  logic [3:0]        w_step_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  tile_addr_t        r_raddr;
  tile_addr_t        w_raddr_nxt;
  logic              r_we;
  logic              w_we_nxt;
  tile_addr_t        r_waddr;
  tile_addr_t        w_waddr_nxt;
  tile_t             r_wdata;
  tile_t             w_wdata_nxt;
  logic              r_blast;
  logic              w_blast_nxt;

  logic              w_push;
  tile_addr_t        w_push_data;
  logic              w_pop;
  logic              w_clr;
  tile_addr_t        w_head;
  logic              w_empty;
  logic              w_end_dir;
  nbr_t              w_nbr;

  assign w_nbr = neighbour(r_centre, r_dir, r_step);

  blast_list #(
    .DEPTH  (LIST_DEPTH),
    .DATA_W (ADDR_W)
  ) u_blast_list (
    .i_clk   (i_pclk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_centre_nxt = r_centre;
    w_dir_nxt    = r_dir;
    w_step_nxt   = r_step;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_raddr_nxt  = r_raddr;
    w_we_nxt     = 1'b0;
    w_waddr_nxt  = r_waddr;   // write address/data hold between strobes
    w_wdata_nxt  = r_wdata;
    w_blast_nxt  = 1'b0;
    w_push       = 1'b0;
    w_push_data  = r_centre;
    w_pop        = 1'b0;
    w_clr        = 1'b0;
    w_end_dir    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_place) begin
          w_centre_nxt = i_place_addr;
          w_raddr_nxt  = i_place_addr;
          w_busy_nxt   = 1'b1;
          w_clr        = 1'b1;
          w_state_nxt  = ST_CHK_WAIT;
        end
      end

      ST_CHK_WAIT: w_state_nxt = ST_CHK_EVAL;

      ST_CHK_EVAL: begin
        if (i_rdata == TILE_PATH) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_centre;
          w_wdata_nxt = TILE_BOMB;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FUSE;
        end else begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_FUSE: begin
        if (i_tick) begin
          if (r_cnt == CNT_W'(FUSE_TICKS - 1)) begin
            w_state_nxt = ST_BLAST_START;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_BLAST_START: begin
        w_we_nxt    = 1'b1;
        w_waddr_nxt = r_centre;
        w_wdata_nxt = TILE_EXPL;
        w_push      = 1'b1;
        w_push_data = r_centre;
        w_blast_nxt = 1'b1;
        w_dir_nxt   = DIR_UP;
        w_step_nxt  = 4'd1;
        w_state_nxt = ST_SCAN_ISSUE;
      end

      ST_SCAN_ISSUE: begin
        if ((r_step > 4'(RANGE)) || !w_nbr.valid) begin
          w_end_dir = 1'b1;
        end else begin
          w_raddr_nxt = w_nbr.addr;
          w_state_nxt = ST_SCAN_WAIT;
        end
      end

      ST_SCAN_WAIT: w_state_nxt = ST_SCAN_EVAL;

      ST_SCAN_EVAL: begin
        // o_raddr still holds the neighbour that was just read.
        if (i_rdata == TILE_PATH) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_raddr;
          w_wdata_nxt = TILE_EXPL;
          w_push      = 1'b1;
          w_push_data = r_raddr;
          w_step_nxt  = r_step + 4'd1;
          w_state_nxt = ST_SCAN_ISSUE;
        end else if (i_rdata == TILE_OBS2) begin
          // Breakable obstacle is destroyed but also absorbs the blast.
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_raddr;
          w_wdata_nxt = TILE_EXPL;
          w_push      = 1'b1;
          w_push_data = r_raddr;
          w_end_dir   = 1'b1;
        end else begin
          w_end_dir = 1'b1;
        end
      end

      ST_HOLD: begin
        if (i_tick) begin
          if (r_cnt == CNT_W'(BLAST_TICKS - 1)) begin
            w_state_nxt = ST_CLEAR;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_CLEAR: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_we_nxt    = 1'b1;
          w_waddr_nxt = w_head;
          w_wdata_nxt = TILE_PATH;
        end else begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Shared by both ways a direction can finish.
    if (w_end_dir) begin
      if (r_dir == DIR_RIGHT) begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_HOLD;
      end else begin
        w_dir_nxt   = dir_t'(r_dir + 2'd1);
        w_step_nxt  = 4'd1;
        w_state_nxt = ST_SCAN_ISSUE;
      end
    end
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_centre <= '0;
      r_dir    <= DIR_UP;
      r_step   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_raddr  <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_blast  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_centre <= w_centre_nxt;
      r_dir    <= w_dir_nxt;
      r_step   <= w_step_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_raddr  <= w_raddr_nxt;
      r_we     <= w_we_nxt;
      r_waddr  <= w_waddr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_blast  <= w_blast_nxt;
    end
  end

  assign o_busy  = r_busy;
  assign o_raddr = r_raddr;
  assign o_we    = r_we;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;
  assign o_blast = r_blast;

endmodule

// File: tb/tb_bomb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bomb_ctrl
// Self-checking bench for bomb_ctrl with a behavioural map RAM. Expected
// write sequences and final maps come from a tile-walking reference model.
// ---------------------------------------------------------------------------
module tb_bomb_ctrl;

  localparam int FUSE    = 3;
  localparam int BLAST   = 4;
  localparam int RNG     = 2;
  localparam int TIMEOUT = 3000;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       tick       = 1'b0;
  logic       place      = 1'b0;
  logic [7:0] place_addr = 8'h00;
  logic       busy;
  logic [7:0] raddr;
  logic [3:0] rdata      = 4'h0;
  logic       we;
  logic [7:0] waddr;
  logic [3:0] wdata;
  logic       blast;

  int total = 0;
  int bad   = 0;

  logic [3:0]  ram      [256];
  logic [3:0]  init_map [256];
  logic [3:0]  mdl      [256];
  logic        load = 1'b0;
  logic [11:0] wlog[$];
  int          blast_cnt  = 0;
  logic [12:0] blast_snap = '0;
  logic [11:0] exp_w[$];
  logic [7:0]  exp_list[$];

  always #5 clk = ~clk;

  bomb_ctrl #(
    .FUSE_TICKS  (FUSE),
    .BLAST_TICKS (BLAST),
    .RANGE       (RNG)
  ) dut (
    .i_pclk       (clk),
    .i_rst_n      (rst_n),
    .i_tick       (tick),
    .i_place      (place),
    .i_place_addr (place_addr),
    .o_busy       (busy),
    .o_raddr      (raddr),
    .i_rdata      (rdata),
    .o_we         (we),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .o_blast      (blast)
  );

  // Map RAM with one cycle read latency, plus a write/blast monitor.
  always @(posedge clk) begin
    rdata <= ram[raddr];
    if (load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_map[i];
    end else if (we) begin
      ram[waddr] <= wdata;
      wlog.push_back({waddr, wdata});
    end
    if (blast) begin
      blast_cnt  <= blast_cnt + 1;
      blast_snap <= {we, waddr, wdata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_map(input logic [3:0] v);
    for (int i = 0; i < 256; i++) init_map[i] = v;
  endtask

  task automatic load_map();
    for (int i = 0; i < 256; i++) mdl[i] = init_map[i];
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic pulse_place(input logic [7:0] a);
    @(negedge clk);
    place      = 1'b1;
    place_addr = a;
    @(negedge clk);
    place      = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Reference model: walk outwards from the centre over the model map.
  task automatic build_expected(input logic [7:0] c);
    int x, y, dx, dy;
    logic [7:0] a;
    exp_w.delete();
    exp_list.delete();
    if (mdl[c] != 4'd1) return;
    exp_w.push_back({c, 4'd4});
    exp_list.push_back(c);
    for (int d = 0; d < 4; d++) begin
      dx = (d == 2) ? -1 : (d == 3) ? 1 : 0;
      dy = (d == 0) ? -1 : (d == 1) ? 1 : 0;
      for (int s = 1; s <= RNG; s++) begin
        x = int'(c[3:0]) + dx * s;
        y = int'(c[7:4]) + dy * s;
        if (x < 0 || x > 15 || y < 0 || y > 15) break;
        a = 8'(y * 16 + x);
        if (mdl[a] == 4'd1) begin
          exp_list.push_back(a);
        end else if (mdl[a] == 4'd3) begin
          exp_list.push_back(a);
          break;
        end else begin
          break;
        end
      end
    end
    foreach (exp_list[i]) exp_w.push_back({exp_list[i], 4'd5});
    foreach (exp_list[i]) exp_w.push_back({exp_list[i], 4'd1});
  endtask

  // Drive frame ticks until the controller goes idle, then compare the
  // complete write sequence and the final map against the model.
  task automatic finish_run(input string tag, input int base, input bit stray,
                            input logic [7:0] stray_addr);
    int cyc, mism;
    cyc = 0;
    while (busy === 1'b1 && cyc < TIMEOUT) begin
      tick = (cyc % 10 == 9);
      if (stray && cyc == 12) begin
        place      = 1'b1;
        place_addr = stray_addr;
      end else begin
        place = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    tick  = 1'b0;
    place = 1'b0;
    check({tag, " done_in_time"}, 32'(cyc < TIMEOUT), 32'd1);
    @(negedge clk);
    check({tag, " nwrites"}, wlog.size() - base, exp_w.size());
    for (int i = 0; i < exp_w.size() && base + i < wlog.size(); i++)
      check($sformatf("%s w%0d", tag, i), 32'(wlog[base + i]), 32'(exp_w[i]));
    foreach (exp_list[i]) mdl[exp_list[i]] = 4'd1;
    mism = 0;
    for (int a = 0; a < 256; a++) if (ram[a] !== mdl[a]) mism++;
    check({tag, " map"}, mism, 0);
  endtask

  task automatic run_bomb(input logic [7:0] c, input string tag, input bit stray,
                          input logic [7:0] stray_addr);
    int base;
    load_map();
    build_expected(c);
    base = wlog.size();
    pulse_place(c);
    finish_run(tag, base, stray, stray_addr);
  endtask

  initial begin
    int base, b0, cyc;
    logic [7:0] c;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {busy, we, blast, raddr, waddr, wdata}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Placement timing and full blast order on an all-path map
    fill_map(4'd1);
    load_map();
    build_expected(8'h55);
    base = wlog.size();
    pulse_place(8'h55);
    check("t1 busy c1", busy, 1);
    check("t1 raddr c1", raddr, 8'h55);
    check("t1 we c1", we, 0);
    @(negedge clk);
    check("t1 we c2", we, 0);
    @(negedge clk);
    check("t1 bomb write c3", {we, waddr, wdata}, {1'b1, 8'h55, 4'd4});
    b0 = blast_cnt;
    repeat (FUSE - 1) pulse_tick();
    check("t1 no early blast", blast_cnt - b0, 0);
    pulse_tick();
    check("t1 blast pulse", blast_cnt - b0, 1);
    check("t1 blast with centre write", blast_snap, {1'b1, 8'h55, 4'd5});
    finish_run("t1", base, 1'b0, 8'h00);

    // Non-path tile: no write, busy for two cycles
    fill_map(4'd1);
    init_map[8'h33] = 4'd2;
    load_map();
    base = wlog.size();
    pulse_place(8'h33);
    check("t2 busy c1", busy, 1);
    @(negedge clk);
    check("t2 busy c2", busy, 1);
    @(negedge clk);
    check("t2 busy c3", busy, 0);
    @(negedge clk);
    check("t2 nwrites", wlog.size() - base, 0);

    // Map edge, indestructible and destructible obstacles
    fill_map(4'd1);
    init_map[8'h02] = 4'd3;
    init_map[8'h11] = 4'd2;
    run_bomb(8'h01, "t4", 1'b0, 8'h00);

    // Second placement during the fuse is ignored; next one is accepted
    fill_map(4'd1);
    run_bomb(8'h55, "t5a", 1'b1, 8'h22);
    run_bomb(8'h22, "t5b", 1'b0, 8'h00);

    // Asynchronous reset in the middle of the scan
    fill_map(4'd1);
    load_map();
    pulse_place(8'h55);
    b0  = blast_cnt;
    cyc = 0;
    while (blast_cnt == b0 && cyc < TIMEOUT) begin
      tick = (cyc % 10 == 9);
      @(negedge clk);
      cyc++;
    end
    tick = 1'b0;
    check("t6 blast reached", 32'(cyc < TIMEOUT), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6 outputs in reset", {busy, we, blast, raddr, waddr, wdata}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    fill_map(4'd1);
    run_bomb(8'h2a, "t6 after", 1'b0, 8'h00);

    // Randomised maps and bomb positions
    for (int n = 0; n < 10; n++) begin
      int r;
      for (int i = 0; i < 256; i++) begin
        r = int'($urandom_range(0, 9));
        init_map[i] = (r <= 5) ? 4'd1 : (r == 6) ? 4'd2 : (r == 7) ? 4'd3 :
                      (r == 8) ? 4'd0 : 4'(4 + $urandom_range(0, 1));
      end
      c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) init_map[c] = 4'd1;
      run_bomb(c, $sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), c ^ 8'h11);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
